// File: rtl/alu_pkg.sv
// Shared op-code, instruction-type and decoded-field definitions for the
// decode stage and alu_control.
package alu_pkg;

    localparam int WIDTH_INSTR      = 16;
    localparam int WIDTH_OP_CODE    = 4;
    localparam int WIDTH_INSTR_TYPE = 1;
    localparam int WIDTH_REG_IDX    = 4;
    localparam int WIDTH_DATA       = 16;
    localparam int WIDTH_COUNT      = 16;

    localparam logic [WIDTH_OP_CODE-1:0] OP_REG   = 4'b0000;
    localparam logic [WIDTH_OP_CODE-1:0] OP_AND   = 4'b0001;
    localparam logic [WIDTH_OP_CODE-1:0] OP_OR    = 4'b0010;
    localparam logic [WIDTH_OP_CODE-1:0] OP_XOR   = 4'b0011;
    localparam logic [WIDTH_OP_CODE-1:0] OP_LSH   = 4'b0100;
    localparam logic [WIDTH_OP_CODE-1:0] OP_ADD   = 4'b0101;
    localparam logic [WIDTH_OP_CODE-1:0] OP_ADDU  = 4'b0110;
    localparam logic [WIDTH_OP_CODE-1:0] OP_ALSHU = 4'b0110;
    localparam logic [WIDTH_OP_CODE-1:0] OP_ADDC  = 4'b0111;
    localparam logic [WIDTH_OP_CODE-1:0] OP_SHIFT = 4'b1000;
    localparam logic [WIDTH_OP_CODE-1:0] OP_SUB   = 4'b1001;
    localparam logic [WIDTH_OP_CODE-1:0] OP_SUBC  = 4'b1010;
    localparam logic [WIDTH_OP_CODE-1:0] OP_CMP   = 4'b1011;

    localparam logic [WIDTH_INSTR_TYPE-1:0] INSTR_TYPE_STATIC = 1'b0;
    localparam logic [WIDTH_INSTR_TYPE-1:0] INSTR_TYPE_SHIFT  = 1'b1;

    typedef struct packed {
        logic [WIDTH_OP_CODE-1:0]    op_code;
        logic [WIDTH_INSTR_TYPE-1:0] instr_type;
        logic [WIDTH_REG_IDX-1:0]    rdest;
        logic [WIDTH_REG_IDX-1:0]    rsrc;
        logic [WIDTH_DATA-1:0]       imm;
        logic                        use_imm;
        logic                        illegal;
    } dec_fields_t;

    function automatic logic is_alu_code(input logic [WIDTH_OP_CODE-1:0] code);
        case (code)
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU, OP_ADDC,
            OP_SUB, OP_SUBC, OP_CMP: is_alu_code = 1'b1;
            default:                 is_alu_code = 1'b0;
        endcase
    endfunction

    // Arithmetic immediates are signed; logical ones and ADDU are unsigned.
    function automatic logic is_signed_imm(input logic [WIDTH_OP_CODE-1:0] code);
        case (code)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: is_signed_imm = 1'b1;
            default:                                  is_signed_imm = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of a CR16-style instruction word into decoded fields
// plus a legality flag; illegal words yield all-zero fields with illegal set.
module instr_field_decode
    import alu_pkg::*;
(
    input  logic [WIDTH_INSTR-1:0] instr,
    output dec_fields_t            fields,
    output logic                   legal
);

    logic [WIDTH_OP_CODE-1:0] op_s;
    logic [WIDTH_OP_CODE-1:0] ext_s;

    assign op_s  = instr[15:12];
    assign ext_s = instr[7:4];

    // Field extraction and legality check.
    always_comb begin
        fields            = '0;
        legal             = 1'b0;
        fields.instr_type = INSTR_TYPE_STATIC;
        fields.rdest      = instr[11:8];
        fields.rsrc       = instr[3:0];
        if (op_s == OP_REG) begin
            legal          = is_alu_code(ext_s);
            fields.op_code = ext_s;
        end else if (is_alu_code(op_s)) begin
            legal          = 1'b1;
            fields.op_code = op_s;
            fields.use_imm = 1'b1;
            if (is_signed_imm(op_s)) begin
                fields.imm = {{(WIDTH_DATA-8){instr[7]}}, instr[7:0]};
            end else begin
                fields.imm = {{(WIDTH_DATA-8){1'b0}}, instr[7:0]};
            end
        end else if (op_s == OP_SHIFT) begin
            fields.instr_type = INSTR_TYPE_SHIFT;
            if ((ext_s == OP_LSH) || (ext_s == OP_ALSHU)) begin
                legal          = 1'b1;
                fields.op_code = ext_s;
            end else if (ext_s[3:1] == 3'b000) begin
                legal          = 1'b1;
                fields.op_code = OP_LSH;
                fields.use_imm = 1'b1;
                fields.imm     = {{(WIDTH_DATA-5){instr[4]}}, instr[4:0]};
            end else begin
                legal = 1'b0;
            end
        end else begin
            legal = 1'b0;
        end

        if (!legal) begin
            fields         = '0;
            fields.illegal = 1'b1;
        end else begin
            fields.illegal = 1'b0;
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: field decode feeding a two-entry skid buffer and a transfer
// counter. Define DECODE_ILLEGAL_FLAG_EN to forward illegal words flagged.
module instr_decode_stage
    import alu_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH_INSTR-1:0]      in_instr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH_OP_CODE-1:0]    out_op_code,
    output logic [WIDTH_INSTR_TYPE-1:0] out_instr_type,
    output logic [WIDTH_REG_IDX-1:0]    out_rdest,
    output logic [WIDTH_REG_IDX-1:0]    out_rsrc,
    output logic [WIDTH_DATA-1:0]       out_imm,
    output logic                        out_use_imm,
    output logic                        out_illegal,
    output logic [WIDTH_COUNT-1:0]      decode_count
);

    localparam logic [WIDTH_COUNT-1:0] COUNT_ONE = {{(WIDTH_COUNT-1){1'b0}}, 1'b1};

    dec_fields_t dec_s;
    dec_fields_t enq_fields_s;
    logic        dec_legal_s;
    logic        accept_s;
    logic        enq_s;
    logic        xfer_s;

    dec_fields_t             main_d,       main_q;
    dec_fields_t             skid_d,       skid_q;
    logic                    main_valid_d, main_valid_q;
    logic                    skid_valid_d, skid_valid_q;
    logic                    in_ready_d,   in_ready_q;
    logic [WIDTH_COUNT-1:0]  count_d,      count_q;

    instr_field_decode u_field_decode (
        .instr  (in_instr),
        .fields (dec_s),
        .legal  (dec_legal_s)
    );

    assign accept_s = in_valid && in_ready_q;
    assign xfer_s   = main_valid_q && out_ready;

`ifdef DECODE_ILLEGAL_FLAG_EN
    assign enq_s        = accept_s && (dec_legal_s || dec_s.illegal);
    assign enq_fields_s = dec_s;
`else
    // Illegal words are consumed but never stored, so the stored flag stays 0.
    assign enq_s        = accept_s && dec_legal_s;
    always_comb begin
        enq_fields_s         = dec_s;
        enq_fields_s.illegal = 1'b0;
    end
`endif

    // Next-state for the main/skid entries, ready and transfer counter.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        count_d      = count_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (xfer_s) begin
                count_d = count_q + COUNT_ONE;
            end else begin
                count_d = count_q;
            end
            if (!main_valid_q) begin
                if (enq_s) begin
                    main_d       = enq_fields_s;
                    main_valid_d = 1'b1;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (xfer_s) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else if (enq_s) begin
                    main_d = enq_fields_s;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else begin
                if (enq_s) begin
                    skid_d       = enq_fields_s;
                    skid_valid_d = 1'b1;
                end else begin
                    skid_valid_d = skid_valid_q;
                end
            end
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            count_q      <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            count_q      <= count_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = main_valid_q;
    assign out_op_code    = main_q.op_code;
    assign out_instr_type = main_q.instr_type;
    assign out_rdest      = main_q.rdest;
    assign out_rsrc       = main_q.rsrc;
    assign out_imm        = main_q.imm;
    assign out_use_imm    = main_q.use_imm;
    assign out_illegal    = main_q.illegal;
    assign decode_count   = count_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed vectors plus random
// traffic against a queue-based reference model.
module tb_instr_decode_stage;

`ifdef DECODE_ILLEGAL_FLAG_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op_code;
    logic [0:0]  out_instr_type;
    logic [3:0]  out_rdest;
    logic [3:0]  out_rsrc;
    logic [15:0] out_imm;
    logic        out_use_imm;
    logic        out_illegal;
    logic [15:0] decode_count;

    instr_decode_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_op_code    (out_op_code),
        .out_instr_type (out_instr_type),
        .out_rdest      (out_rdest),
        .out_rsrc       (out_rsrc),
        .out_imm        (out_imm),
        .out_use_imm    (out_use_imm),
        .out_illegal    (out_illegal),
        .decode_count   (decode_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int op;
        int typ;
        int rd;
        int rs;
        int imm;
        bit use_imm;
        bit ill;
    } exp_t;

    exp_t q[$];
    int   model_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_decode(input int w, output bit legal);
        int   op  = (w >> 12) & 15;
        int   ext = (w >> 4) & 15;
        int   lo8 = w & 255;
        int   lo5 = w & 31;
        exp_t e;
        e.rd = (w >> 8) & 15;
        e.rs = w & 15;
        e.op = 0; e.typ = 0; e.imm = 0; e.use_imm = 0; e.ill = 0;
        legal = 1;
        if (op == 0 && (ext inside {1, 2, 3, 5, 6, 7, 9, 10, 11})) begin
            e.op = ext;
        end else if (op inside {1, 2, 3, 5, 6, 7, 9, 10, 11}) begin
            e.op = op;
            e.use_imm = 1;
            if ((op inside {5, 7, 9, 10, 11}) && lo8 >= 128) e.imm = lo8 + 'hFF00;
            else e.imm = lo8;
        end else if (op == 8 && (ext == 4 || ext == 6)) begin
            e.op = ext;
            e.typ = 1;
        end else if (op == 8 && ext < 2) begin
            e.op = 4;
            e.typ = 1;
            e.use_imm = 1;
            e.imm = (lo5 >= 16) ? lo5 + 'hFFE0 : lo5;
        end else begin
            legal = 0;
            e.op = 0; e.typ = 0; e.rd = 0; e.rs = 0; e.imm = 0; e.use_imm = 0; e.ill = 1;
        end
        return e;
    endfunction

    task automatic check_outputs();
        check_eq("valid", out_valid, q.size() > 0);
        check_eq("in_ready", in_ready, q.size() < 2);
        check_eq("count", decode_count, model_count);
        if (q.size() > 0) begin
            check_eq("op_code", out_op_code, q[0].op);
            check_eq("instr_type", out_instr_type, q[0].typ);
            check_eq("imm", out_imm, q[0].imm);
            check_eq("use_imm", out_use_imm, q[0].use_imm);
            check_eq("illegal", out_illegal, q[0].ill);
            if (!q[0].ill) begin
                check_eq("rdest", out_rdest, q[0].rd);
                check_eq("rsrc", out_rsrc, q[0].rs);
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check at the next negedge.
    task automatic step(input bit v, input logic [15:0] w, input bit rdy, input bit fl);
        bit   legal;
        bit   acc;
        exp_t e;
        in_valid = v;
        in_instr = w;
        out_ready = rdy;
        flush = fl;
        e = model_decode(int'(w), legal);
        acc = v && (q.size() < 2);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) begin
                void'(q.pop_front());
                model_count = (model_count + 1) & 'hFFFF;
            end
            if (acc && (legal || ILL_EN)) q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".valid"}, out_valid, 1'b0);
        check_eq({tag, ".illegal"}, out_illegal, 1'b0);
        check_eq({tag, ".use_imm"}, out_use_imm, 1'b0);
        check_eq({tag, ".op"}, out_op_code, 4'h0);
        check_eq({tag, ".type"}, out_instr_type, 1'b0);
        check_eq({tag, ".rdest"}, out_rdest, 4'h0);
        check_eq({tag, ".rsrc"}, out_rsrc, 4'h0);
        check_eq({tag, ".imm"}, out_imm, 16'h0000);
        check_eq({tag, ".count"}, decode_count, 16'h0000);
        check_eq({tag, ".in_ready"}, in_ready, 1'b1);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 3))
            0: w[15:12] = 4'h0;
            1: w[15:12] = 4'h8;
            default: w[15:12] = w[15:12];
        endcase
        return w;
    endfunction

    int saved_count;

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        // Backpressured stream A, B, C, then drain in consecutive cycles.
        step(1'b1, 16'h0A15, 1'b0, 1'b0);
        check_eq("abc.in_ready_a", in_ready, 1'b1);
        step(1'b1, 16'h0B25, 1'b0, 1'b0);
        check_eq("abc.in_ready_b", in_ready, 1'b0);
        step(1'b1, 16'h0C35, 1'b0, 1'b0);
        check_eq("abc.hold_a", out_rdest, 4'hA);
        step(1'b1, 16'h0C35, 1'b1, 1'b0);
        check_eq("abc.out_b", out_rdest, 4'hB);
        check_eq("abc.ready_up", in_ready, 1'b1);
        step(1'b1, 16'h0C35, 1'b1, 1'b0);
        check_eq("abc.out_c", out_rdest, 4'hC);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check_eq("abc.count", decode_count, 16'd3);

        // Directed decode vectors.
        step(1'b1, 16'h0155, 1'b1, 1'b0);
        check_eq("v0155.valid", out_valid, 1'b1);
        check_eq("v0155.op", out_op_code, 4'b0101);
        check_eq("v0155.rdest", out_rdest, 4'd1);
        check_eq("v0155.rsrc", out_rsrc, 4'd5);
        check_eq("v0155.use_imm", out_use_imm, 1'b0);
        step(1'b1, 16'h52FD, 1'b1, 1'b0);
        check_eq("v52FD.op", out_op_code, 4'b0101);
        check_eq("v52FD.imm", out_imm, 16'hFFFD);
        check_eq("v52FD.use_imm", out_use_imm, 1'b1);
        step(1'b1, 16'h12FD, 1'b1, 1'b0);
        check_eq("v12FD.op", out_op_code, 4'b0001);
        check_eq("v12FD.imm", out_imm, 16'h00FD);
        step(1'b1, 16'h831F, 1'b1, 1'b0);
        check_eq("v831F.op", out_op_code, 4'b0100);
        check_eq("v831F.type", out_instr_type, 1'b1);
        check_eq("v831F.imm", out_imm, 16'hFFFF);
        step(1'b1, 16'h8367, 1'b1, 1'b0);
        check_eq("v8367.op", out_op_code, 4'b0110);
        check_eq("v8367.rsrc", out_rsrc, 4'd7);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush with two entries held and a simultaneous input word.
        step(1'b1, 16'h0A15, 1'b0, 1'b0);
        step(1'b1, 16'h0B25, 1'b0, 1'b0);
        saved_count = int'(decode_count);
        step(1'b1, 16'h0C35, 1'b1, 1'b1);
        check_eq("flush.valid", out_valid, 1'b0);
        check_eq("flush.in_ready", in_ready, 1'b1);
        check_eq("flush.count", decode_count, saved_count);

        // Illegal word followed by a legal one.
        saved_count = int'(decode_count);
        step(1'b1, 16'hF000, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_FLAG_EN
        check_eq("illegal.valid", out_valid, 1'b1);
        check_eq("illegal.flag", out_illegal, 1'b1);
        check_eq("illegal.op", out_op_code, 4'h0);
`else
        check_eq("illegal.valid", out_valid, 1'b0);
        check_eq("illegal.count", decode_count, saved_count);
`endif
        step(1'b1, 16'h0155, 1'b1, 1'b0);
        check_eq("after_ill.valid", out_valid, 1'b1);
        check_eq("after_ill.op", out_op_code, 4'b0101);
        check_eq("after_ill.illegal", out_illegal, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_word(), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset in the middle of a held stream.
        step(1'b1, 16'h0A15, 1'b0, 1'b0);
        step(1'b1, 16'h0B25, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        q.delete();
        model_count = 0;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_outputs();

        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 1) != 0), rand_word(), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
